// File: rtl/ula_sequencer.sv
// ula_sequencer: multi-cycle operation controller for the ULA datapath.
// On a start request it captures a, b and the selector. It then either
// runs a one-step op (add, sub, and, or, xor, or an error outcome) or
// iterates WIDTH steps for multiply (shift-add) and divide (restoring
// subtract). It presents a registered result, flags and a one-cycle done
// pulse.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     synchronous active-low reset
//   start_i    request, acted on at its rising edge
//   a_i, b_i   unsigned operands
//   seletor_i  operation select (000 add .. 110 div, 111 invalid)
//   busy_o     high in EXEC, ITER and DONE
//   done_o     one-cycle pulse; outputs valid from this cycle on
//   result_o   2*WIDTH-bit registered result
//   carry_o    add carry-out / sub borrow, else 0
//   zero_o     result == 0, forced 0 on error
//   error_o    divide-by-zero or invalid selector
module ula_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2:0]         seletor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               carry_o,
    output logic               zero_o,
    output logic               error_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpDiv = 3'b110;

    typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

    state_e             state_q;
    logic               start_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q, quo_q;
    logic               busy_q, done_q, carry_q, zero_q, error_q;
    logic [2*WIDTH-1:0] result_q;

    logic               req;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] exec_res;
    logic               exec_carry, exec_err;
    logic [2*WIDTH-1:0] mul_add, prod_d, iter_res;
    logic [CntW-1:0]    bit_idx;
    logic [WIDTH:0]     trial, trial_sub;
    logic               ge;
    logic [WIDTH-1:0]   rem_d, quo_d;

    assign req = start_i & ~start_q;

    // Single-step outcome from the latched operands.
    always_comb begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = {1'b0, a_q} - {1'b0, b_q};
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_err   = 1'b0;
        case (op_q)
            OpAdd: begin
                exec_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                exec_carry = sum[WIDTH];
            end
            OpSub: begin
                exec_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                exec_carry = diff[WIDTH];  // borrow, set when a < b
            end
            OpAnd:   exec_res = {{WIDTH{1'b0}}, a_q & b_q};
            OpOr:    exec_res = {{WIDTH{1'b0}}, a_q | b_q};
            OpXor:   exec_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OpMul:   exec_res = '0;  // never routed to EXEC
            OpDiv:   exec_err = 1'b1;  // only reaches EXEC with b == 0
            default: exec_err = 1'b1;
        endcase
    end

    // One iteration step: shift-add multiply / restoring divide, MSB first.
    always_comb begin
        mul_add   = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        prod_d    = prod_q + mul_add;
        bit_idx   = LastCnt - cnt_q;
        trial     = {rem_q, a_q[bit_idx]};
        trial_sub = trial - {1'b0, b_q};
        ge        = (trial >= {1'b0, b_q});
        rem_d     = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ge};
        iter_res  = (op_q == OpMul) ? prod_d : {rem_d, quo_d};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            start_q <= start_i;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        op_q   <= seletor_i;
                        cnt_q  <= '0;
                        prod_q <= '0;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        busy_q <= 1'b1;
                        if (seletor_i == OpMul || (seletor_i == OpDiv && b_i != '0)) begin
                            state_q <= StIter;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    result_q <= exec_err ? '0 : exec_res;
                    carry_q  <= exec_err ? 1'b0 : exec_carry;
                    zero_q   <= !exec_err && (exec_res == '0);
                    error_q  <= exec_err;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StIter: begin
                    prod_q <= prod_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result_q <= iter_res;
                        carry_q  <= 1'b0;
                        zero_q   <= (iter_res == '0);
                        error_q  <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_ula_sequencer.sv
module tb_ula_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic [2:0] sel;
    logic       busy, done, carry, zero, error;
    logic [7:0] result;

    int tests = 0;
    int fails = 0;

    logic [7:0] prev_res;
    logic       prev_c, prev_z, prev_e;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[16];

    ula_sequencer #(.WIDTH(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .seletor_i (sel),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .carry_o   (carry),
        .zero_o    (zero),
        .error_o   (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, scramble inputs while busy, then watch
    // 8 cycles: done timing, busy length, held outputs and final values.
    task automatic run_op(input vec_t v, input int idx);
        int   first;
        int   ndone;
        int   nbusy;
        logic hold_ok;
        logic [7:0] r;
        logic rc, rz, re, rbusy;
        first   = -1;
        ndone   = 0;
        nbusy   = 0;
        hold_ok = 1'b1;
        r = '0; rc = 1'b0; rz = 1'b0; re = 1'b0; rbusy = 1'b0;
        @(negedge clk);
        a = v.a; b = v.b; sel = v.sel; start = 1'b1;
        @(negedge clk);  // after request edge N
        start = 1'b0;
        if (busy) nbusy++;
        a = ~v.a; b = v.b ^ 4'h5; sel = v.sel ^ 3'b011;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    r = result; rc = carry; rz = zero; re = error; rbusy = busy;
                end
            end else if (first < 0) begin
                if (result !== prev_res || carry !== prev_c || zero !== prev_z ||
                    error !== prev_e) hold_ok = 1'b0;
            end
        end
        chk($sformatf("v%0d done_latency", idx), first, v.lat);
        chk($sformatf("v%0d done_count", idx), ndone, 1);
        chk($sformatf("v%0d busy_cycles", idx), nbusy, v.lat + 1);
        chk($sformatf("v%0d busy_in_done", idx), rbusy, 1);
        chk($sformatf("v%0d hold_before_done", idx), hold_ok, 1);
        chk($sformatf("v%0d result", idx), r, v.res);
        chk($sformatf("v%0d carry", idx), rc, v.c);
        chk($sformatf("v%0d zero", idx), rz, v.z);
        chk($sformatf("v%0d error", idx), re, v.e);
        prev_res = v.res; prev_c = v.c; prev_z = v.z; prev_e = v.e;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_carry"}, carry, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        int   ndone;
        logic [7:0] r;

        //            a      b      sel     res    c     z     e    lat
        vecs[0]  = '{4'd9,  4'd8,  3'b000, 8'h01, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'd3,  4'd5,  3'b001, 8'h0E, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'd12, 4'd10, 3'b010, 8'h08, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd5,  4'd10, 3'b011, 8'h0F, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'd6,  4'd6,  3'b100, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{4'd15, 4'd15, 3'b101, 8'hE1, 1'b0, 1'b0, 1'b0, 4};
        vecs[6]  = '{4'd13, 4'd4,  3'b110, 8'h13, 1'b0, 1'b0, 1'b0, 4};
        vecs[7]  = '{4'd7,  4'd7,  3'b110, 8'h01, 1'b0, 1'b0, 1'b0, 4};
        vecs[8]  = '{4'd9,  4'd0,  3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        vecs[9]  = '{4'd3,  4'd2,  3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        vecs[10] = '{4'd0,  4'd0,  3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{4'd0,  4'd7,  3'b101, 8'h00, 1'b0, 1'b1, 1'b0, 4};
        vecs[12] = '{4'd5,  4'd5,  3'b001, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{4'd2,  4'd5,  3'b110, 8'h20, 1'b0, 1'b0, 1'b0, 4};
        vecs[14] = '{4'd15, 4'd1,  3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[15] = '{4'd13, 4'd11, 3'b101, 8'h8F, 1'b0, 1'b0, 1'b0, 4};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        prev_res = '0; prev_c = 1'b0; prev_z = 1'b0; prev_e = 1'b0;

        for (int i = 0; i < 16; i++) run_op(vecs[i], i);

        // Start held high: exactly one operation.
        @(negedge clk);
        a = 4'd2; b = 4'd3; sel = 3'b000; start = 1'b1;
        ndone = 0; r = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done) begin ndone++; r = result; end
        end
        start = 1'b0;
        chk("held_start_done_count", ndone, 1);
        chk("held_start_result", r, 8'h05);

        // Second rising edge of start during ITER is dropped.
        @(negedge clk);
        a = 4'd3; b = 4'd5; sel = 3'b101; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 4'd1; b = 4'd1; sel = 3'b000; start = 1'b1;
        ndone = 0; r = '0;
        @(negedge clk); start = 1'b0;
        if (done) begin ndone++; r = result; end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) begin ndone++; r = result; end
        end
        chk("drop_req_done_count", ndone, 1);
        chk("drop_req_result", r, 8'h0F);
        chk("drop_req_idle", busy, 0);

        // Reset while multiply is in ITER.
        @(negedge clk);
        a = 4'd15; b = 4'd15; sel = 3'b101; start = 1'b1;
        @(negedge clk); start = 1'b0;   // after edge N
        @(negedge clk);                 // after edge N+1
        @(negedge clk); rst_n = 1'b0;   // after edge N+2
        @(negedge clk); rst_n = 1'b1;   // after reset edge N+3
        chk_cleared("midop_reset");
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midop_reset_no_done", ndone, 0);
        prev_res = '0; prev_c = 1'b0; prev_z = 1'b0; prev_e = 1'b0;
        run_op(vecs[0], 100);

        // Reset wins over a simultaneous request.
        @(negedge clk);
        rst_n = 1'b0; a = 4'd1; b = 4'd1; sel = 3'b000; start = 1'b1;
        @(negedge clk);
        chk("rst_vs_req_busy", busy, 0);
        chk("rst_vs_req_result", result, 0);
        rst_n = 1'b1; start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_vs_req_no_done", ndone, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
